sram_march_bist: RTL and testbench
==================================

# sram_march_bist

March C- built-in self-test controller for the 1024x8 single-port SRAM macro. It sits directly upstream of the macro's BIST port: it drives the `A_BIST_*` inputs and checks `A_DOUT` against expected data. It runs on request and reports pass/fail with first-failure diagnostics. The functional port is untouched; the test simply steers the macro via `A_BIST_EN`.

## Interface
Parameters:
- `ADDR_W`, 10, address width; N = 2^ADDR_W words
- `DATA_W`, 8, data width

Ports:
- `clk`  in  1  core clock; integrator also ties macro `A_BIST_CLK` to `clk`
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  run request, sampled only in IDLE
- `bg`  in  DATA_W  data background; "0" = `bg`, "1" = `~bg`; latched at start
- `busy`  out  1  test in progress
- `done`  out  1  level; test finished, held until next accepted start
- `fail`  out  1  valid with `done`; first mismatch seen
- `fail_elem`  out  3  March element index (0..5) of first mismatch
- `fail_addr`  out  ADDR_W  address of first mismatch
- `fail_data`  out  DATA_W  read data at first mismatch
- `bist_en`, `bist_men`, `bist_wen`, `bist_ren`  out  1 each  to macro BIST controls
- `bist_addr`  out  ADDR_W  to `A_BIST_ADDR`
- `bist_din`  out  DATA_W  to `A_BIST_DIN`
- `bist_bm`  out  DATA_W  to `A_BIST_BM`; all ones while busy
- `dout`  in  DATA_W  from macro `A_DOUT`

## Operation
- Elements: E0 ⇑(w0); E1 ⇑(r0,w1); E2 ⇑(r1,w0); E3 ⇓(r0,w1); E4 ⇓(r1,w0); E5 ⇑(r0). ⇑ means address 0..N-1; ⇓ means N-1..0.
- One macro op per cycle, 10N ops total. In two-op elements, the read and the write hit the same address on consecutive cycles.
- States and transitions:
  - IDLE → RUN on `start`.
  - RUN → FLUSH after the last op of E5.
  - RUN → DONE on a mismatch.
  - FLUSH → DONE.
  - DONE → RUN on `start`.
- In IDLE and DONE, all `bist_*` outputs are 0; `bist_en` is 0, so the functional port owns the macro.
- In RUN and FLUSH: `bist_en`=1 and `bist_bm`=all ones.
  - Read op: `bist_men`=1, `bist_ren`=1.
  - Write op: `bist_men`=1, `bist_wen`=1, `bist_din` = pattern.
  - FLUSH issues no op (`bist_men`=0).
- Compare: read data is checked the cycle after the read is presented, against registered expected data.
- First mismatch: captures `fail_elem`/`fail_addr`/`fail_data` and sets `fail`. The state then goes to DONE at the next edge; the op already presented in that cycle completes.
- `start` is ignored while busy. `start` in DONE clears `fail`, `done` and the diagnostics, then reruns.
- Reset, including mid-run, forces IDLE on the next edge. Reset value of every output is 0.

## Timing
- All outputs are registered.
- `start` sampled high at edge k: `busy`=1 from cycle k+1; op 0 (E0 w0 to address 0) is presented in cycle k+1.
- Op i (0 ≤ i < 10N) is presented in cycle k+1+i.
- Macro read latency is 1 cycle: `dout` for a read presented in cycle t is compared in cycle t+1.
- Fault-free run:
  - FLUSH occupies cycle k+1+10N.
  - From cycle k+2+10N: `done`=1, `busy`=0, `fail`=0.
  - Total `busy` = 10N+1 cycles (10241 for N=1024).
- Failing run: mismatch compared in cycle c gives `done`=1, `busy`=0, `fail`=1 from cycle c+1.
- Address counter wraps only at element boundaries: the element advances when the address reaches N-1 (⇑) or 0 (⇓) on the element's last op.

## Structure
- Shared package `sram_bist_pkg` holds:
  - the state enum (IDLE/RUN/FLUSH/DONE);
  - the element index constants E0..E5;
  - per-element constants: direction, op count, read-expect polarity and write polarity.
- One sub-module, `sram_bist_addr_gen`: loadable up/down ADDR_W counter with `first`/`last` flags.
- Comparator and diagnostic capture stay in the top level.

## Test plan
- Fault-free 1-cycle-latency SRAM model, `bg`=0x00 → `busy` exactly 10241 cycles, then `done`=1, `fail`=0; model ends holding 0x00 everywhere.
- Op-order check, `bg`=0x5A:
  - cycles 0..1023: writes of 0x5A to addresses 0..1023;
  - cycle 1024: read of address 0;
  - cycle 1025: write 0xA5 to address 0;
  - first E3 op: read of address 1023.
- Stuck-at-0 on bit 3 of address 0x155, `bg`=0x00 → `fail`=1, `fail_elem`=2, `fail_addr`=0x155, `fail_data`=0xF7. `done` rises one cycle after the compare; no further macro ops.
- Down-order coupling fault (write 1 to address 0x200 flips bit 0 of address 0x1FF), `bg`=0x00 → `fail_elem`=3, `fail_addr`=0x1FF, `fail_data`=0x01.
- `rst_n` low at busy cycle 5000 → all outputs 0 next cycle. A later `start` gives a full 10241-cycle clean run.
- `start` pulsed during RUN → ignored. `start` in DONE after a fail → diagnostics clear and a full rerun follows.

Source files
------------

// File: rtl/sram_bist_pkg.sv
// Shared types and March C- element tables for the SRAM BIST controller.
// Element tables are indexed by element number; bit i describes element Ei.
package sram_bist_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush,
    StDone
  } state_e;

  localparam logic [2:0] E0 = 3'd0;
  localparam logic [2:0] E1 = 3'd1;
  localparam logic [2:0] E2 = 3'd2;
  localparam logic [2:0] E3 = 3'd3;
  localparam logic [2:0] E4 = 3'd4;
  localparam logic [2:0] E5 = 3'd5;
  localparam logic [2:0] LastElem = E5;

  // E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 dn(r0,w1); E4 dn(r1,w0); E5 up(r0)
  localparam logic [7:0] ElemDown  = 8'b0001_1000;
  localparam logic [7:0] ElemHasRd = 8'b0011_1110;
  localparam logic [7:0] ElemHasWr = 8'b0001_1111;
  localparam logic [7:0] ElemRdPol = 8'b0001_0100;
  localparam logic [7:0] ElemWrPol = 8'b0000_1010;

  function automatic logic elem_down(input logic [2:0] e);
    return ElemDown[e];
  endfunction

  function automatic logic elem_has_rd(input logic [2:0] e);
    return ElemHasRd[e];
  endfunction

  function automatic logic [1:0] elem_ops(input logic [2:0] e);
    return {1'b0, ElemHasRd[e]} + {1'b0, ElemHasWr[e]};
  endfunction

  function automatic logic elem_two_ops(input logic [2:0] e);
    return elem_ops(e) == 2'd2;
  endfunction

  function automatic logic elem_rd_pol(input logic [2:0] e);
    return ElemRdPol[e];
  endfunction

  function automatic logic elem_wr_pol(input logic [2:0] e);
    return ElemWrPol[e];
  endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Loadable up/down address counter for the March sequencer.
// Direction is captured on load so first/last stay stable for the whole element.
module sram_bist_addr_gen #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              down_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              first_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] addr_q;
  logic              down_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q <= '0;
      down_q <= 1'b0;
    end else if (load_i) begin
      addr_q <= down_i ? '1 : '0;
      down_q <= down_i;
    end else if (step_i) begin
      addr_q <= down_q ? addr_q - 1'b1 : addr_q + 1'b1;
    end
  end

  assign addr_o  = addr_q;
  assign first_o = down_q ? (addr_q == '1) : (addr_q == '0);
  assign last_o  = down_q ? (addr_q == '0) : (addr_q == '1);

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST controller driving the BIST port of a single-port SRAM macro.
// Registered op outputs describe the op presented this cycle; reads are checked one cycle later.
module sram_march_bist
  import sram_bist_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] bg,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [2:0]        fail_elem,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic              bist_en,
  output logic              bist_men,
  output logic              bist_wen,
  output logic              bist_ren,
  output logic [ADDR_W-1:0] bist_addr,
  output logic [DATA_W-1:0] bist_din,
  output logic [DATA_W-1:0] bist_bm,
  input  logic [DATA_W-1:0] dout
);

  state_e            state_q;
  logic [2:0]        elem_q;
  logic              phase_q;
  logic [DATA_W-1:0] bg_q;

  logic              cmp_valid_q;
  logic [DATA_W-1:0] cmp_exp_q;
  logic [2:0]        cmp_elem_q;
  logic [ADDR_W-1:0] cmp_addr_q;

  logic              busy_q, done_q, fail_q;
  logic [2:0]        fail_elem_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [DATA_W-1:0] fail_data_q;
  logic              bist_en_q, bist_men_q, bist_wen_q, bist_ren_q;
  logic [DATA_W-1:0] bist_din_q, bist_bm_q;

  logic [ADDR_W-1:0] ag_addr;
  logic              ag_load, ag_down, ag_step, ag_first, ag_last;
  logic              unused_ag_first;

  logic [2:0]        nxt_elem;
  logic              nxt_phase, nxt_rd, run_end, mismatch;
  logic [DATA_W-1:0] bg_cur, nxt_din, rd_exp;

  assign unused_ag_first = ag_first;

  assign mismatch = cmp_valid_q && (dout != cmp_exp_q);

  // Next op: second op at the same address, else advance the address or the element.
  always_comb begin
    nxt_elem  = elem_q;
    nxt_phase = 1'b0;
    run_end   = 1'b0;
    ag_load   = 1'b0;
    ag_down   = 1'b0;
    ag_step   = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        nxt_elem = E0;
        ag_load  = start;
      end
      StRun: begin
        if (mismatch) begin
          ag_load = 1'b1;
        end else if (elem_two_ops(elem_q) && !phase_q) begin
          nxt_phase = 1'b1;
        end else if (ag_last) begin
          ag_load = 1'b1;
          if (elem_q == LastElem) begin
            run_end = 1'b1;
          end else begin
            nxt_elem = elem_q + 3'd1;
            ag_down  = elem_down(nxt_elem);
          end
        end else begin
          ag_step = 1'b1;
        end
      end
      default: ;
    endcase
    bg_cur  = (state_q == StRun) ? bg_q : bg;
    nxt_rd  = elem_has_rd(nxt_elem) && !nxt_phase;
    nxt_din = nxt_rd ? '0 : (elem_wr_pol(nxt_elem) ? ~bg_cur : bg_cur);
    rd_exp  = elem_rd_pol(elem_q) ? ~bg_q : bg_q;
  end

  sram_bist_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .load_i (ag_load),
    .down_i (ag_down),
    .step_i (ag_step),
    .addr_o (ag_addr),
    .first_o(ag_first),
    .last_o (ag_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      elem_q      <= E0;
      phase_q     <= 1'b0;
      bg_q        <= '0;
      cmp_valid_q <= 1'b0;
      cmp_exp_q   <= '0;
      cmp_elem_q  <= '0;
      cmp_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_elem_q <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      bist_en_q   <= 1'b0;
      bist_men_q  <= 1'b0;
      bist_wen_q  <= 1'b0;
      bist_ren_q  <= 1'b0;
      bist_din_q  <= '0;
      bist_bm_q   <= '0;
    end else begin
      cmp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q     <= StRun;
            elem_q      <= nxt_elem;
            phase_q     <= 1'b0;
            bg_q        <= bg;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_elem_q <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            bist_en_q   <= 1'b1;
            bist_bm_q   <= '1;
            bist_men_q  <= 1'b1;
            bist_ren_q  <= nxt_rd;
            bist_wen_q  <= !nxt_rd;
            bist_din_q  <= nxt_din;
          end
        end
        StRun: begin
          cmp_valid_q <= bist_ren_q;
          cmp_exp_q   <= rd_exp;
          cmp_elem_q  <= elem_q;
          cmp_addr_q  <= ag_addr;
          if (mismatch) begin
            // The op presented this cycle completes; nothing further is issued.
            state_q     <= StDone;
            cmp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            fail_q      <= 1'b1;
            fail_elem_q <= cmp_elem_q;
            fail_addr_q <= cmp_addr_q;
            fail_data_q <= dout;
            bist_en_q   <= 1'b0;
            bist_bm_q   <= '0;
            bist_men_q  <= 1'b0;
            bist_ren_q  <= 1'b0;
            bist_wen_q  <= 1'b0;
            bist_din_q  <= '0;
          end else if (run_end) begin
            state_q    <= StFlush;
            bist_men_q <= 1'b0;
            bist_ren_q <= 1'b0;
            bist_wen_q <= 1'b0;
            bist_din_q <= '0;
          end else begin
            elem_q     <= nxt_elem;
            phase_q    <= nxt_phase;
            bist_men_q <= 1'b1;
            bist_ren_q <= nxt_rd;
            bist_wen_q <= !nxt_rd;
            bist_din_q <= nxt_din;
          end
        end
        StFlush: begin
          // Last E5 read is compared here.
          state_q   <= StDone;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          bist_en_q <= 1'b0;
          bist_bm_q <= '0;
          if (mismatch) begin
            fail_q      <= 1'b1;
            fail_elem_q <= cmp_elem_q;
            fail_addr_q <= cmp_addr_q;
            fail_data_q <= dout;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign fail_elem = fail_elem_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign bist_en   = bist_en_q;
  assign bist_men  = bist_men_q;
  assign bist_wen  = bist_wen_q;
  assign bist_ren  = bist_ren_q;
  assign bist_addr = ag_addr;
  assign bist_din  = bist_din_q;
  assign bist_bm   = bist_bm_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: 1-cycle-latency SRAM model with injectable faults and
// an independent March C- op stream pushed to a scoreboard queue at each start.
module tb_sram_march_bist;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned N = 1 << ADDR_W;
  localparam int unsigned RunBusy = 10 * N + 1;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
  } op_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] bg = '0;
  logic              busy, done, fail;
  logic [2:0]        fail_elem;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_data;
  logic              bist_en, bist_men, bist_wen, bist_ren;
  logic [ADDR_W-1:0] bist_addr;
  logic [DATA_W-1:0] bist_din, bist_bm;
  logic [DATA_W-1:0] dout = '0;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  sram_march_bist #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bg       (bg),
    .busy     (busy),
    .done     (done),
    .fail     (fail),
    .fail_elem(fail_elem),
    .fail_addr(fail_addr),
    .fail_data(fail_data),
    .bist_en  (bist_en),
    .bist_men (bist_men),
    .bist_wen (bist_wen),
    .bist_ren (bist_ren),
    .bist_addr(bist_addr),
    .bist_din (bist_din),
    .bist_bm  (bist_bm),
    .dout     (dout)
  );

  always #5 clk = ~clk;

  // SRAM model. Stuck-at-0 on bit 3 of 0x155; writing 1 to 0x200 forces bit 0 of 0x1FF to 1.
  logic [DATA_W-1:0] mem [N];
  bit fault_sa = 1'b0;
  bit fault_cf = 1'b0;

  always @(posedge clk) begin
    if (bist_en === 1'b1 && bist_men === 1'b1) begin
      if (bist_wen) begin
        mem[bist_addr] <= (mem[bist_addr] & ~bist_bm) | (bist_din & bist_bm);
        if (fault_cf && bist_addr == 10'h200 && bist_din[0]) mem[10'h1FF][0] <= 1'b1;
      end
      if (bist_ren) begin
        dout <= (fault_sa && bist_addr == 10'h155) ? (mem[bist_addr] & 8'hF7) : mem[bist_addr];
      end
    end
  end

  // Scoreboard: expected op stream, popped as the DUT presents each op.
  op_t exp_q[$];
  int unsigned busy_total = 0;
  int unsigned ops_total = 0;
  int unsigned stream_err = 0;

  always @(negedge clk) begin
    if (busy === 1'b1) busy_total <= busy_total + 1;
    if (bist_en === 1'b1 && bist_men === 1'b1) begin
      ops_total <= ops_total + 1;
      if (exp_q.size() == 0) begin
        stream_err <= stream_err + 1;
      end else begin
        if (bist_wen !== exp_q[0].we || bist_ren !== ~exp_q[0].we ||
            bist_addr !== exp_q[0].addr || bist_bm !== 8'hFF ||
            (exp_q[0].we && bist_din !== exp_q[0].din))
          stream_err <= stream_err + 1;
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_op(input logic we, input int unsigned a, input logic [DATA_W-1:0] d);
    op_t o;
    o.we   = we;
    o.addr = ADDR_W'(a);
    o.din  = d;
    exp_q.push_back(o);
  endtask

  // Reads carry their expected data in din; only write data is compared.
  task automatic push_march(input logic [DATA_W-1:0] b);
    exp_q.delete();
    for (int a = 0; a < N; a++) push_op(1'b1, a, b);
    for (int a = 0; a < N; a++) begin push_op(1'b0, a, b);  push_op(1'b1, a, ~b); end
    for (int a = 0; a < N; a++) begin push_op(1'b0, a, ~b); push_op(1'b1, a, b);  end
    for (int a = N - 1; a >= 0; a--) begin push_op(1'b0, a, b);  push_op(1'b1, a, ~b); end
    for (int a = N - 1; a >= 0; a--) begin push_op(1'b0, a, ~b); push_op(1'b1, a, b);  end
    for (int a = 0; a < N; a++) push_op(1'b0, a, b);
  endtask

  // Leaves the caller at the negedge of the cycle where op 0 is presented.
  task automatic do_start(input logic [DATA_W-1:0] b);
    @(negedge clk);
    start = 1'b1;
    bg    = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget, output bit timed_out);
    int unsigned n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    timed_out = (done !== 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, fail, fail_elem, fail_addr, fail_data} !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_status: got %h, want 0",
               {busy, done, fail, fail_elem, fail_addr, fail_data});
    end
    n_cmp++;
    if ({bist_en, bist_men, bist_wen, bist_ren, bist_addr, bist_din, bist_bm} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_bist: got %h, want 0",
               {bist_en, bist_men, bist_wen, bist_ren, bist_addr, bist_din, bist_bm});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, bist_en} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b, want 000", {busy, done, bist_en});
    end
  endtask

  task automatic test_clean_run(input string tag);
    int unsigned b0, o0, e0, nz;
    bit to;
    fault_sa = 1'b0;
    fault_cf = 1'b0;
    push_march(8'h00);
    b0 = busy_total; o0 = ops_total; e0 = stream_err;
    do_start(8'h00);
    wait_done(RunBusy + 16, to);
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL %s_timeout: done never rose", tag); end
    n_cmp++;
    if (busy_total - b0 !== RunBusy) begin
      n_fail++;
      $display("FAIL %s_busy_cycles: got %0d, want %0d", tag, busy_total - b0, RunBusy);
    end
    n_cmp++;
    if (ops_total - o0 !== 10 * N || stream_err - e0 !== 0) begin
      n_fail++;
      $display("FAIL %s_op_stream: ops %0d errors %0d, want ops %0d errors 0",
               tag, ops_total - o0, stream_err - e0, 10 * N);
    end
    n_cmp++;
    if ({done, busy, fail, bist_en} !== 4'b1000) begin
      n_fail++;
      $display("FAIL %s_status: got done/busy/fail/en %b, want 1000", tag,
               {done, busy, fail, bist_en});
    end
    nz = 0;
    for (int a = 0; a < N; a++) if (mem[a] !== 8'h00) nz++;
    n_cmp++;
    if (nz != 0) begin n_fail++; $display("FAIL %s_mem_final: %0d nonzero words, want 0", tag, nz); end
  endtask

  task automatic test_op_order();
    int unsigned b0, e0, wr_bad;
    bit to;
    push_march(8'h5A);
    b0 = busy_total; e0 = stream_err;
    do_start(8'h5A);
    wr_bad = 0;
    for (int i = 0; i < N; i++) begin
      if (!(bist_men && bist_wen && !bist_ren && bist_addr == ADDR_W'(i) && bist_din == 8'h5A))
        wr_bad++;
      @(negedge clk);
    end
    n_cmp++;
    if (wr_bad != 0) begin n_fail++; $display("FAIL order_e0_writes: %0d bad ops, want 0", wr_bad); end
    n_cmp++;
    if ({bist_men, bist_ren, bist_wen, bist_addr} !== {3'b110, 10'd0}) begin
      n_fail++;
      $display("FAIL order_cycle1024: got men/ren/wen %b addr %h, want 110 addr 000",
               {bist_men, bist_ren, bist_wen}, bist_addr);
    end
    @(negedge clk);
    n_cmp++;
    if ({bist_men, bist_ren, bist_wen, bist_addr, bist_din} !== {3'b101, 10'd0, 8'hA5}) begin
      n_fail++;
      $display("FAIL order_cycle1025: got men/ren/wen %b addr %h din %h, want 101 000 a5",
               {bist_men, bist_ren, bist_wen}, bist_addr, bist_din);
    end
    start = 1'b1;  // must be ignored while busy
    @(negedge clk);
    start = 1'b0;
    repeat (5 * N - 1026) @(negedge clk);
    n_cmp++;
    if ({bist_men, bist_ren, bist_wen, bist_addr} !== {3'b110, 10'h3FF}) begin
      n_fail++;
      $display("FAIL order_e3_first: got men/ren/wen %b addr %h, want 110 addr 3ff",
               {bist_men, bist_ren, bist_wen}, bist_addr);
    end
    wait_done(RunBusy, to);
    n_cmp++;
    if (to || busy_total - b0 !== RunBusy || stream_err - e0 !== 0 || fail !== 1'b0) begin
      n_fail++;
      $display("FAIL start_ignored: busy %0d errors %0d fail %b, want %0d 0 0",
               busy_total - b0, stream_err - e0, fail, RunBusy);
    end
  endtask

  task automatic test_stuck_fault();
    int unsigned b0, o0, e0;
    bit to;
    fault_sa = 1'b1;
    push_march(8'h00);
    b0 = busy_total; o0 = ops_total; e0 = stream_err;
    do_start(8'h00);
    wait_done(RunBusy, to);
    n_cmp++;
    if (to || {fail, fail_elem, fail_addr, fail_data} !== {1'b1, 3'd2, 10'h155, 8'hF7}) begin
      n_fail++;
      $display("FAIL stuck_diag: got fail %b elem %0d addr %h data %h, want 1 2 155 f7",
               fail, fail_elem, fail_addr, fail_data);
    end
    // Read of 0x155 in E2 is op 3754, compared while op 3755 is presented.
    n_cmp++;
    if (busy_total - b0 !== 3756 || ops_total - o0 !== 3756 || stream_err - e0 !== 0) begin
      n_fail++;
      $display("FAIL stuck_timing: busy %0d ops %0d errors %0d, want 3756 3756 0",
               busy_total - b0, ops_total - o0, stream_err - e0);
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (ops_total - o0 !== 3756 || bist_en !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL stuck_quiet: ops %0d en %b done %b, want 3756 0 1",
               ops_total - o0, bist_en, done);
    end
  endtask

  task automatic test_rerun_after_fail();
    int unsigned b0;
    bit to;
    fault_sa = 1'b0;
    push_march(8'h00);
    b0 = busy_total;
    do_start(8'h00);
    n_cmp++;
    if ({busy, done, fail, fail_elem, fail_addr, fail_data} !== {1'b1, 23'd0}) begin
      n_fail++;
      $display("FAIL rerun_clear: got busy/done/fail %b diag %h/%h/%h, want 100 0/0/0",
               {busy, done, fail}, fail_elem, fail_addr, fail_data);
    end
    wait_done(RunBusy + 16, to);
    n_cmp++;
    if (to || busy_total - b0 !== RunBusy || fail !== 1'b0) begin
      n_fail++;
      $display("FAIL rerun_full: busy %0d fail %b, want %0d 0", busy_total - b0, fail, RunBusy);
    end
  endtask

  task automatic test_coupling_fault();
    int unsigned b0;
    bit to;
    fault_cf = 1'b1;
    push_march(8'h00);
    b0 = busy_total;
    do_start(8'h00);
    wait_done(RunBusy, to);
    n_cmp++;
    if (to || {fail, fail_elem, fail_addr, fail_data} !== {1'b1, 3'd3, 10'h1FF, 8'h01}) begin
      n_fail++;
      $display("FAIL coupling_diag: got fail %b elem %0d addr %h data %h, want 1 3 1ff 01",
               fail, fail_elem, fail_addr, fail_data);
    end
    // E3 read of 0x1FF is op 6144, compared one cycle later.
    n_cmp++;
    if (busy_total - b0 !== 6146) begin
      n_fail++;
      $display("FAIL coupling_timing: busy %0d, want 6146", busy_total - b0);
    end
    fault_cf = 1'b0;
  endtask

  task automatic test_mid_reset();
    int unsigned b0;
    push_march(8'h00);
    b0 = busy_total;
    do_start(8'h00);
    repeat (4999) @(negedge clk);
    n_cmp++;
    if (busy_total - b0 !== 4999 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_pre: busy count %0d busy %b, want 4999 1", busy_total - b0, busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, fail, fail_elem, fail_addr, fail_data, bist_en, bist_men, bist_wen,
         bist_ren, bist_addr, bist_din, bist_bm} !== 54'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: busy %b en %b men %b addr %h bm %h, want all 0",
               busy, bist_en, bist_men, bist_addr, bist_bm);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_clean_run("clean");
    test_op_order();
    test_stuck_fault();
    test_rerun_after_fail();
    test_coupling_fault();
    test_mid_reset();
    test_clean_run("after_reset");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
